// File: rtl/sim_ctrl.sv
// rtl/sim_ctrl.sv - memory-mapped simulation-control peripheral (tohost, watchdog, cycle counter, signatures)
//
// Purpose: gives firmware an end-of-test mechanism. A TOHOST write of 1 means
// pass; any other odd value means fail, with the code in value>>1. A watchdog
// ends a hung test with TIMEOUT, and a free-running 64-bit cycle counter is
// exposed both as a port and as registers.
//
// Optional feature macro: SIM_CTRL_SIG_FIFO_EN (signature FIFO plus the
// SIG_PUSH/SIG_POP/SIG_STAT registers). When it is undefined those registers
// read 0 and ignore writes.
//
// Ports:
//   clk_i, rst_n_i              clock, asynchronous active-low reset
//   req_valid_i/req_ready_o     bus request handshake; ready is always 1
//   req_we_i, req_addr_i        write enable, byte address
//   req_wdata_i                 write data
//   rsp_valid_o, rsp_rdata_o    one-cycle response strobe and read data
//   done_o/pass_o/fail_o        end-of-test status
//   timeout_o                   watchdog expired
//   fail_code_o                 failing TOHOST value >> 1
//   cycle_count_o               cycles spent in RUN since reset release
module sim_ctrl #(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h1000_0000,
  parameter int                DATA_W         = 32,
  parameter int                SIG_DEPTH      = 16,
  parameter int                TIMEOUT_CYCLES = 100000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] fail_code_o,
  output logic [63:0]       cycle_count_o
);

  localparam logic [31:0] LP_TMO = 32'(TIMEOUT_CYCLES);
  // A kick also counts as this cycle's decrement, so the timeout lands exactly
  // TIMEOUT_CYCLES cycles after the cycle that issued the kick.
  localparam logic [31:0] LP_RELOAD = (LP_TMO == 32'd0) ? 32'd0 : LP_TMO - 32'd1;

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t            r_state;
  logic              r_done, r_pass, r_fail, r_timeout;
  logic [DATA_W-1:0] r_tohost;
  logic [DATA_W-1:0] r_fail_code;
  logic [31:0]       r_wdog;
  logic [63:0]       r_cycle;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_hit;
  logic [2:0]        w_off;
  logic              w_wr;
  logic              w_rd;
  logic              w_tohost_wr;
  logic              w_kick;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  assign w_hit       = req_valid_i && (req_addr_i[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
  assign w_off       = req_addr_i[4:2];
  assign w_wr        = w_hit && req_we_i;
  assign w_rd        = w_hit && !req_we_i;
  assign w_tohost_wr = w_wr && (w_off == 3'd0);
  assign w_kick      = w_wr && (w_off == 3'd6);
  assign w_unused    = &{1'b0, req_addr_i[1:0]};

`ifdef SIM_CTRL_SIG_FIFO_EN
  localparam int AW = (SIG_DEPTH > 1) ? $clog2(SIG_DEPTH) : 1;

  logic [DATA_W-1:0] r_sig_mem [SIG_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_sig_cnt;
  logic              r_ovf;
  logic              w_push, w_pop, w_full;

  assign w_full = (r_sig_cnt == (AW+1)'(SIG_DEPTH));
  assign w_push = w_wr && (w_off == 3'd3);
  // Popping an empty FIFO is a plain read of 0 and leaves the pointers alone.
  assign w_pop  = w_rd && (w_off == 3'd4) && (r_sig_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (w_push && !w_full) r_sig_mem[r_wr_ptr] <= req_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_sig_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_push && !w_full) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_sig_cnt <= r_sig_cnt + 1'b1;
      end
      if (w_push && w_full) r_ovf <= 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_sig_cnt <= r_sig_cnt - 1'b1;
      end
    end
  end
`endif

  // Read data reflects register state before this request's own update, so a
  // SIG_POP returns the pre-pop head.
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_off)
        3'd0: w_rdata = r_tohost;
        3'd1: w_rdata = DATA_W'(r_cycle[31:0]);
        3'd2: w_rdata = DATA_W'(r_cycle[63:32]);
`ifdef SIM_CTRL_SIG_FIFO_EN
        3'd4: w_rdata = (r_sig_cnt != '0) ? r_sig_mem[r_rd_ptr] : '0;
        3'd5: begin
          w_rdata[AW:0]     = r_sig_cnt;
          w_rdata[DATA_W-1] = r_ovf;
        end
`endif
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= req_valid_i;
      r_rsp_rdata <= w_rdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_RUN;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_tohost    <= '0;
      r_fail_code <= '0;
      r_wdog      <= LP_TMO;
      r_cycle     <= 64'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_cycle <= r_cycle + 64'd1;
          if (w_tohost_wr) r_tohost <= req_wdata_i;
          // Finishing write first, then kick, then expiry: a finishing write
          // or a kick in the expiry cycle wins over the timeout.
          if (w_tohost_wr && (req_wdata_i == DATA_W'(1))) begin
            r_state <= S_PASS;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (w_tohost_wr && req_wdata_i[0]) begin
            r_state     <= S_FAIL;
            r_done      <= 1'b1;
            r_fail      <= 1'b1;
            r_fail_code <= req_wdata_i >> 1;
          end else if (w_kick) begin
            r_wdog <= LP_RELOAD;
          end else if (LP_TMO != 32'd0) begin
            // The count reaches 0 at this edge, so TIMEOUT shows next cycle.
            if (r_wdog <= 32'd1) begin
              r_state   <= S_TIMEOUT;
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
            end
            r_wdog <= (r_wdog == 32'd0) ? 32'd0 : r_wdog - 32'd1;
          end
        end
        default: begin
          // Terminal states hold until reset.
        end
      endcase
    end
  end

  assign req_ready_o   = 1'b1;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign done_o        = r_done;
  assign pass_o        = r_pass;
  assign fail_o        = r_fail;
  assign timeout_o     = r_timeout;
  assign fail_code_o   = r_fail_code;
  assign cycle_count_o = r_cycle;

endmodule

// File: tb/tb_sim_ctrl.sv
// tb/tb_sim_ctrl.sv - directed self-checking bench for sim_ctrl
module tb_sim_ctrl;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_TOH  = BASE + 32'h00;
  localparam logic [31:0] A_CLO  = BASE + 32'h04;
  localparam logic [31:0] A_PUSH = BASE + 32'h0C;
  localparam logic [31:0] A_POP  = BASE + 32'h10;
  localparam logic [31:0] A_STAT = BASE + 32'h14;
  localparam logic [31:0] A_KICK = BASE + 32'h18;
  localparam logic [31:0] A_UNM  = BASE + 32'h1C;
  localparam logic [31:0] A_MISS = 32'h2000_0000;

`ifdef SIM_CTRL_SIG_FIFO_EN
  localparam bit FIFO_ON = 1'b1;
`else
  localparam bit FIFO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        done, pass, fail, timeout;
  logic [31:0] fail_code;
  logic [63:0] cycle_count;

  int cyc;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sim_ctrl #(
    .ADDR_W(32), .BASE_ADDR(BASE), .DATA_W(32), .SIG_DEPTH(4), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .done_o(done), .pass_o(pass), .fail_o(fail), .timeout_o(timeout),
    .fail_code_o(fail_code), .cycle_count_o(cycle_count)
  );

  // Cycle k is the interval after the k-th clock edge since reset release;
  // the bench always sits at the falling edge inside that interval.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto_cycle(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic vld);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    step();
    rd = rsp_rdata; vld = rsp_valid;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", req_ready); else n_pass++;
    n_checks++; if ({rsp_valid, done, pass, fail, timeout} !== 5'b0) $display("FAIL reset_flags: got %05b want 00000", {rsp_valid, done, pass, fail, timeout}); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'h0 || fail_code !== 32'h0) $display("FAIL reset_data: got rdata=%0h code=%0h want 0 0", rsp_rdata, fail_code); else n_pass++;
    n_checks++; if (cycle_count !== 64'd0) $display("FAIL reset_cycle: got %0d want 0", cycle_count); else n_pass++;
  endtask

  task automatic test_pass();
    logic [31:0] rd; logic v;
    do_reset();
    goto_cycle(10); bus(1'b1, A_KICK, 32'h0, rd, v);
    goto_cycle(25); bus(1'b1, A_KICK, 32'h0, rd, v);
    goto_cycle(40); bus(1'b1, A_KICK, 32'h0, rd, v);
    goto_cycle(50); bus(1'b1, A_TOH, 32'h1, rd, v);
    n_checks++; if ({done, pass, fail, timeout} !== 4'b1100) $display("FAIL pass_status: got %04b want 1100", {done, pass, fail, timeout}); else n_pass++;
    n_checks++; if (v !== 1'b1 || rd !== 32'h0) $display("FAIL pass_wr_rsp: got vld=%0b rd=%0h want 1 0", v, rd); else n_pass++;
    n_checks++; if (cycle_count !== 64'd51) $display("FAIL pass_cycle: got %0d want 51", cycle_count); else n_pass++;
    goto_cycle(70);
    n_checks++; if (cycle_count !== 64'd51) $display("FAIL pass_frozen: got %0d want 51", cycle_count); else n_pass++;
    n_checks++; if ({done, pass, timeout} !== 3'b110) $display("FAIL pass_hold: got %03b want 110", {done, pass, timeout}); else n_pass++;
    bus(1'b0, A_TOH, 32'h0, rd, v);
    n_checks++; if (rd !== 32'h1) $display("FAIL pass_tohost_rd: got %0h want 1", rd); else n_pass++;
  endtask

  task automatic test_fail();
    logic [31:0] rd; logic v;
    do_reset();
    goto_cycle(3); bus(1'b1, A_TOH, 32'h4, rd, v);
    n_checks++; if (done !== 1'b0) $display("FAIL even_no_done: got %0b want 0", done); else n_pass++;
    bus(1'b0, A_TOH, 32'h0, rd, v);
    n_checks++; if (rd !== 32'h4) $display("FAIL even_stored: got %0h want 4", rd); else n_pass++;
    bus(1'b1, A_TOH, 32'h7, rd, v);
    n_checks++; if ({done, pass, fail} !== 3'b101) $display("FAIL fail_status: got %03b want 101", {done, pass, fail}); else n_pass++;
    n_checks++; if (fail_code !== 32'h3) $display("FAIL fail_code: got %0h want 3", fail_code); else n_pass++;
    bus(1'b1, A_TOH, 32'h1, rd, v);
    step();
    n_checks++; if ({done, pass, fail} !== 3'b101 || fail_code !== 32'h3) $display("FAIL fail_sticky: got %03b code=%0h want 101 3", {done, pass, fail}, fail_code); else n_pass++;
    bus(1'b0, A_TOH, 32'h0, rd, v);
    n_checks++; if (rd !== 32'h7) $display("FAIL fail_tohost_rd: got %0h want 7", rd); else n_pass++;
  endtask

  task automatic test_watchdog();
    logic [31:0] rd; logic v;
    do_reset();
    goto_cycle(19);
    n_checks++; if (timeout !== 1'b0) $display("FAIL wd_early: got %0b want 0", timeout); else n_pass++;
    step();
    n_checks++; if ({done, timeout, pass} !== 3'b110) $display("FAIL wd_expire20: got %03b want 110", {done, timeout, pass}); else n_pass++;
    goto_cycle(30);
    n_checks++; if (cycle_count !== 64'd20) $display("FAIL wd_cycle_frozen: got %0d want 20", cycle_count); else n_pass++;

    do_reset();
    goto_cycle(15); bus(1'b1, A_KICK, 32'h0, rd, v);
    goto_cycle(34);
    n_checks++; if (timeout !== 1'b0) $display("FAIL wd_kick_early: got %0b want 0", timeout); else n_pass++;
    step();
    n_checks++; if (timeout !== 1'b1) $display("FAIL wd_kick_expire35: got %0b want 1", timeout); else n_pass++;

    do_reset();
    goto_cycle(19); bus(1'b1, A_TOH, 32'h1, rd, v);
    n_checks++; if ({pass, timeout} !== 2'b10) $display("FAIL wd_race_pass: got %02b want 10", {pass, timeout}); else n_pass++;

    do_reset();
    goto_cycle(19); bus(1'b1, A_KICK, 32'h0, rd, v);
    goto_cycle(38);
    n_checks++; if (timeout !== 1'b0) $display("FAIL wd_race_kick: got %0b want 0", timeout); else n_pass++;
    step();
    n_checks++; if (timeout !== 1'b1) $display("FAIL wd_race_kick_expire39: got %0b want 1", timeout); else n_pass++;
  endtask

  task automatic test_fifo();
    logic [31:0] rd; logic v;
    logic [31:0] pops [5];
    do_reset();
    pops[0] = 32'hA; pops[1] = 32'hB; pops[2] = 32'hC; pops[3] = 32'hD; pops[4] = 32'h0;
    for (int i = 0; i < 5; i++) bus(1'b1, A_PUSH, 32'hA + i, rd, v);
    bus(1'b0, A_STAT, 32'h0, rd, v);
    n_checks++; if (rd !== (FIFO_ON ? 32'h8000_0004 : 32'h0)) $display("FAIL fifo_stat_full: got %0h want %0h", rd, FIFO_ON ? 32'h8000_0004 : 32'h0); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, A_POP, 32'h0, rd, v);
      n_checks++; if (rd !== (FIFO_ON ? pops[i] : 32'h0)) $display("FAIL fifo_pop%0d: got %0h want %0h", i, rd, FIFO_ON ? pops[i] : 32'h0); else n_pass++;
    end
    bus(1'b0, A_STAT, 32'h0, rd, v);
    n_checks++; if (rd !== (FIFO_ON ? 32'h8000_0000 : 32'h0)) $display("FAIL fifo_stat_empty: got %0h want %0h", rd, FIFO_ON ? 32'h8000_0000 : 32'h0); else n_pass++;
  endtask

  task automatic test_bus_edges();
    logic [31:0] rd, r1, r2; logic v, v1, v2; int c0;
    do_reset();
    bus(1'b1, A_TOH, 32'h6, rd, v);
    bus(1'b0, A_UNM, 32'h0, rd, v);
    n_checks++; if (v !== 1'b1 || rd !== 32'h0) $display("FAIL unmapped_rd: got vld=%0b rd=%0h want 1 0", v, rd); else n_pass++;
    bus(1'b0, A_MISS, 32'h0, rd, v);
    n_checks++; if (v !== 1'b1 || rd !== 32'h0) $display("FAIL miss_rd: got vld=%0b rd=%0h want 1 0", v, rd); else n_pass++;
    bus(1'b1, A_MISS, 32'h1, rd, v);
    step();
    n_checks++; if (pass !== 1'b0) $display("FAIL miss_wr_ignored: got %0b want 0", pass); else n_pass++;
    goto_cycle(8);
    c0 = cyc;
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_CLO;
    step(); r1 = rsp_rdata; v1 = rsp_valid;
    step(); r2 = rsp_rdata; v2 = rsp_valid;
    req_valid = 1'b0;
    n_checks++; if (v1 !== 1'b1 || v2 !== 1'b1) $display("FAIL b2b_valid: got %0b%0b want 11", v1, v2); else n_pass++;
    n_checks++; if (r1 !== 32'(c0) || r2 !== 32'(c0 + 1)) $display("FAIL b2b_cycle_lo: got %0d,%0d want %0d,%0d", r1, r2, c0, c0 + 1); else n_pass++;
    step();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rsp_pulse: got %0b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic v;
    do_reset();
    bus(1'b1, A_PUSH, 32'h11, rd, v);
    bus(1'b1, A_PUSH, 32'h22, rd, v);
    bus(1'b1, A_TOH, 32'h1, rd, v);
    n_checks++; if (pass !== 1'b1) $display("FAIL mid_pre_pass: got %0b want 1", pass); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({rsp_valid, done, pass, fail, timeout} !== 5'b0 || cycle_count !== 64'd0 || rsp_rdata !== 32'h0) $display("FAIL mid_async_clear: got flags=%05b cyc=%0d rd=%0h want 0", {rsp_valid, done, pass, fail, timeout}, cycle_count, rsp_rdata); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    bus(1'b0, A_STAT, 32'h0, rd, v);
    n_checks++; if (rd !== 32'h0) $display("FAIL mid_stat_cleared: got %0h want 0", rd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_watchdog();
    test_fifo();
    test_bus_edges();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
